whitening_ctrl: RTL and testbench

WHITENING_CTRL -- requirements
Module: whitening_ctrl

---
 rtl/whitening_ctrl_if.sv | 39 +++
 rtl/whitening_ctrl.sv | 173 +++++++++++++++++
 tb/tb_whitening_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/whitening_ctrl_if.sv
// Byte-source, whitening-LFSR and air-bit signals of the
// whitening transmit controller.
interface whitening_ctrl_if #(
  parameter int CH_IDX_W = 6
);
  logic                start;
  logic                abort;
  logic [CH_IDX_W-1:0] ch_idx;
  logic [31:0]         acc_addr;
  logic [7:0]          len;
  logic                bit_tick;
  logic                byte_req;
  logic                byte_valid;
  logic [7:0]          byte_data;
  logic                wh_init;
  logic                wh_en;
  logic [CH_IDX_W-1:0] wh_ch_idx;
  logic                wh_din;
  logic                wh_dout;
  logic                tx_bit;
  logic                tx_valid;
  logic                busy;
  logic                done;
  logic                err;

  modport master (
    output start, abort, ch_idx, acc_addr, len,
    output bit_tick, byte_valid, byte_data, wh_dout,
    input  byte_req, wh_init, wh_en, wh_ch_idx, wh_din,
    input  tx_bit, tx_valid, busy, done, err
  );

  modport slave (
    input  start, abort, ch_idx, acc_addr, len,
    input  bit_tick, byte_valid, byte_data, wh_dout,
    output byte_req, wh_init, wh_en, wh_ch_idx, wh_din,
    output tx_bit, tx_valid, busy, done, err
  );
endinterface

// File: rtl/whitening_ctrl.sv
// BLE transmit sequencer: preamble, access address, then the
// PDU bytes routed through an external whitening LFSR.
module whitening_ctrl #(
  parameter int CH_IDX_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  whitening_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, INIT, PRE, AA, PDU, DONE
  } state_t;

  state_t state, state_nx;

  logic [CH_IDX_W-1:0] ch_q;
  logic [31:0]         aa_q;
  logic [7:0]          len_q;
  logic [7:0]          hold_q;
  logic [7:0]          shift_q;
  logic                hold_full;
  logic [2:0]          bib;
  logic [5:0]          bit_cnt;
  logic [7:0]          sent_cnt;
  logic [7:0]          fetch_cnt;
  logic                tx_bit_q;
  logic                tx_valid_q;
  logic                err_q;

  logic busy;
  logic in_pdu;
  logic kill;
  logic accept;
  logic reject;
  logic tick;
  logic move;
  logic underrun;
  logic boundary;
  logic raw_bit;
  logic pre_last;
  logic xfer;

  assign busy     = (state != IDLE);
  assign in_pdu   = (state == PDU);
  assign kill     = bus.abort && busy;
  assign boundary = (bib == 3'd0);
  assign pre_last = (state == PRE) && (bit_cnt == 6'd7);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    reject   = 1'b0;
    tick     = 1'b0;
    move     = 1'b0;
    underrun = 1'b0;
    raw_bit  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          if (bus.len != 8'd0) begin
            accept   = 1'b1;
            state_nx = INIT;
          end else begin
            reject = 1'b1;
          end
        end
      end
      INIT: state_nx = PRE;
      PRE: begin
        raw_bit = aa_q[0] ^ bit_cnt[0];
        tick    = bus.bit_tick;
        if (tick && bit_cnt == 6'd7) state_nx = AA;
      end
      AA: begin
        raw_bit = aa_q[bit_cnt[4:0]];
        tick    = bus.bit_tick;
        if (tick && bit_cnt == 6'd31) state_nx = PDU;
      end
      PDU: begin
        raw_bit = boundary ? hold_q[0] : shift_q[0];
        if (bus.bit_tick) begin
          if (boundary && !hold_full) begin
            underrun = 1'b1;
            state_nx = IDLE;
          end else begin
            tick = 1'b1;
            move = boundary;
            if (bib == 3'd7 && sent_cnt == len_q - 8'd1)
              state_nx = DONE;
          end
        end
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // abort beats any strobe or underrun in the same cycle
    if (kill) begin
      state_nx = IDLE;
      tick     = 1'b0;
      move     = 1'b0;
      underrun = 1'b0;
    end
  end

  assign bus.byte_req = busy && (state != DONE) && !hold_full
                        && (fetch_cnt < len_q);
  assign xfer = bus.byte_req && bus.byte_valid && !kill;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_q       <= '0;
      aa_q       <= '0;
      len_q      <= '0;
      hold_q     <= '0;
      shift_q    <= '0;
      hold_full  <= 1'b0;
      bib        <= '0;
      bit_cnt    <= '0;
      sent_cnt   <= '0;
      fetch_cnt  <= '0;
      tx_bit_q   <= 1'b0;
      tx_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      tx_valid_q <= tick;
      err_q      <= reject | underrun;
      if (tick) tx_bit_q <= in_pdu ? bus.wh_dout : raw_bit;
      if (accept) begin
        ch_q      <= bus.ch_idx;
        aa_q      <= bus.acc_addr;
        len_q     <= bus.len;
        hold_full <= 1'b0;
        bib       <= '0;
        bit_cnt   <= '0;
        sent_cnt  <= '0;
        fetch_cnt <= '0;
      end
      if (tick && in_pdu) begin
        bib     <= bib + 3'd1;
        shift_q <= {1'b0, move ? hold_q[7:1] : shift_q[7:1]};
        if (bib == 3'd7) sent_cnt <= sent_cnt + 8'd1;
      end
      if (tick && !in_pdu)
        bit_cnt <= pre_last ? 6'd0 : bit_cnt + 6'd1;
      if (kill) begin
        hold_full <= 1'b0;
      end else if (xfer) begin
        hold_q    <= bus.byte_data;
        hold_full <= 1'b1;
        fetch_cnt <= fetch_cnt + 8'd1;
      end else if (move) begin
        hold_full <= 1'b0;
      end
    end
  end

  assign bus.busy      = busy;
  assign bus.done      = (state == DONE);
  assign bus.err       = err_q;
  assign bus.wh_init   = (state == INIT);
  assign bus.wh_ch_idx = busy ? ch_q : '0;
  assign bus.wh_en     = tick && in_pdu;
  assign bus.wh_din    = in_pdu && raw_bit;
  assign bus.tx_bit    = tx_bit_q;
  assign bus.tx_valid  = tx_valid_q;

endmodule

// File: tb/tb_whitening_ctrl.sv
// Scoreboard bench for whitening_ctrl with a behavioural
// BLE whitening LFSR and a programmable byte source.
module tb_whitening_ctrl;
  localparam int CW = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  whitening_ctrl_if #(.CH_IDX_W(CW)) bus();

  whitening_ctrl #(.CH_IDX_W(CW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] wh_seed(input logic [5:0] c);
    return {c[0], c[1], c[2], c[3], c[4], c[5], 1'b1};
  endfunction

  function automatic logic [6:0] wh_step(input logic [6:0] r);
    return {r[5], r[4], r[3] ^ r[6], r[2], r[1], r[0], r[6]};
  endfunction

  function automatic logic wh_key(input logic [5:0] c, input int n);
    logic [6:0] r;
    r = wh_seed(c);
    for (int i = 0; i < n; i++) r = wh_step(r);
    return r[6];
  endfunction

  // whitening block stand-in
  logic [6:0] lfsr = 7'h0;
  always @(posedge clk)
    if (bus.wh_init)    lfsr <= wh_seed(bus.wh_ch_idx);
    else if (bus.wh_en) lfsr <= wh_step(lfsr);
  assign bus.wh_dout = bus.wh_din ^ lfsr[6];

  int tick_per = 4;
  int tick_cnt = 0;
  always @(posedge clk)
    tick_cnt <= (tick_cnt + 1 >= tick_per) ? 0 : tick_cnt + 1;
  assign bus.bit_tick = (tick_cnt == 0);

  logic [7:0] src_mem [256];
  int src_n    = 0;
  int src_base = 0;
  int xfer_tot = 0;
  int src_i;
  bit withhold = 1'b0;
  assign src_i = xfer_tot - src_base;
  assign bus.byte_valid = (src_i < src_n)
                          && !(withhold && src_i == 1);
  assign bus.byte_data = (src_i < src_n) ? src_mem[src_i[7:0]]
                                         : 8'h00;
  always @(posedge clk)
    if (bus.byte_req && bus.byte_valid) xfer_tot <= xfer_tot + 1;

  bit exp_q [$];
  int tx_tot = 0, done_tot = 0, err_tot = 0, init_tot = 0;
  int wh_tot = 0, early_tot = 0, badch_tot = 0, done_at = 0;
  int pkt_base = 0;
  logic [5:0] cur_ch = '0;

  always @(negedge clk) begin
    if (bus.tx_valid) begin
      if (exp_q.size() == 0) chk("tx_extra", 1, 0);
      else chk("tx_bit", bus.tx_bit, exp_q.pop_front());
    end
    tx_tot <= tx_tot + int'(bus.tx_valid);
    if (bus.done) begin
      done_tot <= done_tot + 1;
      done_at  <= tx_tot + int'(bus.tx_valid);
    end
    if (bus.err)     err_tot  <= err_tot + 1;
    if (bus.wh_init) init_tot <= init_tot + 1;
    if (bus.wh_en) begin
      wh_tot <= wh_tot + 1;
      if (tx_tot + int'(bus.tx_valid) - pkt_base < 40)
        early_tot <= early_tot + 1;
    end
    if (bus.busy && bus.wh_ch_idx != cur_ch)
      badch_tot <= badch_tot + 1;
  end

  task automatic chk_reset(input string nm);
    chk({nm, ".tx_bit"},   bus.tx_bit, 0);
    chk({nm, ".tx_valid"}, bus.tx_valid, 0);
    chk({nm, ".busy"},     bus.busy, 0);
    chk({nm, ".done"},     bus.done, 0);
    chk({nm, ".err"},      bus.err, 0);
    chk({nm, ".byte_req"}, bus.byte_req, 0);
    chk({nm, ".wh_init"},  bus.wh_init, 0);
    chk({nm, ".wh_en"},    bus.wh_en, 0);
    chk({nm, ".wh_ch"},    bus.wh_ch_idx, 0);
  endtask

  function automatic bit exp_bit(input int i, input logic [5:0] c,
                                 input logic [31:0] aa);
    logic [7:0] b;
    int p;
    if (i < 8)  return aa[0] ^ i[0];
    if (i < 40) return aa[i - 8];
    p = i - 40;
    b = src_mem[p / 8];
    return b[p % 8] ^ wh_key(c, p);
  endfunction

  // mode: 0 normal, 1 underrun, 2 start intrudes,
  //       3 abort on 20th AA bit, 4 rst mid-PDU
  task automatic run_pkt(input string nm, input logic [5:0] c,
                         input logic [31:0] aa, input int len,
                         input int per, input int mode);
    int b_tx, b_done, b_err, b_init, b_wh, b_early, b_bad;
    int nexp, nwh;
    bit fin, hit;
    tick_per = per;
    withhold = (mode == 1);
    src_n    = len;
    src_base = xfer_tot;
    exp_q.delete();
    unique case (mode)
      1: nexp = 48;
      3: nexp = 27;
      4: nexp = 50;
      default: nexp = 40 + len * 8;
    endcase
    nwh = (mode == 3) ? 0 : nexp - 40;
    for (int i = 0; i < nexp; i++)
      exp_q.push_back(exp_bit(i, c, aa));
    @(posedge clk); #1;
    b_tx = tx_tot; b_done = done_tot; b_err = err_tot;
    b_init = init_tot; b_wh = wh_tot; b_early = early_tot;
    b_bad = badch_tot;
    pkt_base = tx_tot;
    cur_ch   = c;
    bus.start = 1'b1; bus.ch_idx = c;
    bus.acc_addr = aa; bus.len = len[7:0];
    @(posedge clk); #1;
    bus.start = 1'b0;
    fin = 1'b0; hit = 1'b0;
    for (int cyc = 0; cyc < (40 + len * 8) * per + 40 && !fin;
         cyc++) begin
      bus.start = 1'b0;
      if (mode == 2 && !hit && tx_tot - b_tx >= 45) begin
        bus.start = 1'b1; bus.ch_idx = 6'd3;
        bus.len = 8'd1; bus.acc_addr = ~aa; hit = 1'b1;
      end
      if (mode == 3 && !hit && tx_tot - b_tx >= 27
          && bus.bit_tick) begin
        bus.abort = 1'b1; hit = 1'b1; fin = 1'b1;
      end
      if (mode == 4 && tx_tot - b_tx >= 50) begin
        rst = 1'b1; fin = 1'b1;
      end
      @(posedge clk); #1;
      if (done_tot != b_done || err_tot != b_err) fin = 1'b1;
    end
    bus.start = 1'b0;
    if (!fin) chk({nm, ".timeout"}, 1, 0);
    if (mode == 3) begin
      bus.abort = 1'b0;
      chk({nm, ".ab_busy"},  bus.busy, 0);
      chk({nm, ".ab_req"},   bus.byte_req, 0);
      chk({nm, ".ab_valid"}, bus.tx_valid, 0);
    end
    if (mode == 4) begin
      chk_reset({nm, ".rst"});
      rst = 1'b0;
    end
    chk({nm, ".busy_end"}, bus.busy, 0);
    repeat (4) @(posedge clk);
    #1;
    chk({nm, ".ntx"},   tx_tot - b_tx, nexp);
    chk({nm, ".left"},  exp_q.size(), 0);
    chk({nm, ".done"},  done_tot - b_done,
        (mode == 0 || mode == 2) ? 1 : 0);
    chk({nm, ".err"},   err_tot - b_err, (mode == 1) ? 1 : 0);
    chk({nm, ".init"},  init_tot - b_init, 1);
    chk({nm, ".wh_en"}, wh_tot - b_wh, nwh);
    chk({nm, ".early"}, early_tot - b_early, 0);
    chk({nm, ".ch"},    badch_tot - b_bad, 0);
    if (mode == 0 || mode == 2)
      chk({nm, ".done_at"}, done_at - b_tx, nexp);
    chk({nm, ".busy"}, bus.busy, 0);
  endtask

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.ch_idx = '0;
    bus.acc_addr = '0; bus.len = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    rst = 1'b0;
    repeat (2) @(posedge clk);

    src_mem[0] = 8'h02; src_mem[1] = 8'h01; src_mem[2] = 8'hAA;
    run_pkt("ref37", 6'd37, 32'h8E89BED6, 3, 4, 0);

    for (int i = 0; i < 5; i++) src_mem[i] = 8'($urandom);
    run_pkt("aa1", 6'd5, 32'h12345679, 5, 3, 0);

    for (int i = 0; i < 3; i++) src_mem[i] = 8'($urandom);
    run_pkt("undr", 6'd10, 32'hA5A5F00E, 3, 2, 1);

    @(posedge clk); #1;
    bus.start = 1'b1; bus.len = 8'd0; bus.ch_idx = 6'd9;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("len0.err",  bus.err, 1);
    chk("len0.busy", bus.busy, 0);
    @(posedge clk); #1;
    chk("len0.err_clr", bus.err, 0);
    chk("len0.busy2",   bus.busy, 0);

    for (int i = 0; i < 4; i++) src_mem[i] = 8'($urandom);
    run_pkt("intr", 6'd21, 32'h0BADF00D, 4, 3, 2);

    for (int i = 0; i < 3; i++) src_mem[i] = 8'($urandom);
    run_pkt("abrt", 6'd12, 32'h55AA33CC, 3, 4, 3);

    for (int i = 0; i < 4; i++) src_mem[i] = 8'($urandom);
    run_pkt("rstm", 6'd33, 32'hDEADBEEF, 4, 4, 4);

    for (int i = 0; i < 255; i++) src_mem[i] = 8'($urandom);
    run_pkt("b2b", 6'd17, 32'h71764129, 255, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
